// File: rtl/mips_mem_pkg.sv
// Shared encodings, FSM states and request payload for the data-memory load/store unit.
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC0,
    ST_ACC1,
    ST_RESP
  } lsu_state_e;

  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

  // Only the two low address bits matter for natural alignment.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lsb);
    case (size)
      SZ_HALF: return addr_lsb[0];
      SZ_WORD: return addr_lsb != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Big-endian lane handling: load extraction with sign/zero extension and
// byte merge into a halfword for read-modify-write stores.
module lsu_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic        addr_lsb,
  input  logic [15:0] hold,
  input  logic [15:0] lo,
  input  logic [7:0]  wbyte,
  output logic [31:0] rdata_c,
  output logic [15:0] merged_c
);

  logic [7:0] byte_sel;

  always_comb begin
    byte_sel = addr_lsb ? hold[7:0] : hold[15:8];
    rdata_c  = '0;
    case (size)
      SZ_BYTE: rdata_c = {{24{sgn & byte_sel[7]}}, byte_sel};
      SZ_HALF: rdata_c = {{16{sgn & hold[15]}}, hold};
      SZ_WORD: rdata_c = {hold, lo};
      default: rdata_c = '0;
    endcase
    // Even byte address is the high lane of the halfword.
    merged_c = addr_lsb ? {hold[15:8], wbyte} : {wbyte, hold[7:0]};
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store initiator: splits core byte/half/word accesses into one or two
// 16-bit memory cycles, using read-modify-write for byte stores.
module dmem_lsu
  import mips_mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_write_en,
  output logic        mem_read,
  input  logic [15:0] mem_rdata
);

  lsu_state_e  state, state_nxt;
  lsu_req_t    req;
  logic        err_q;
  logic [15:0] hold, lo;

  logic [1:0]  span_c;
  logic [32:0] last_byte_c;
  logic        acc_err_c;
  logic        two_beat_c;
  logic [31:0] base_addr_c;
  logic [31:0] ld_data_c;
  logic [15:0] merged_c;

  lsu_align u_align (
    .size     (req.size),
    .sgn      (req.sgn),
    .addr_lsb (req.addr[0]),
    .hold     (hold),
    .lo       (lo),
    .wbyte    (req.wdata[7:0]),
    .rdata_c  (ld_data_c),
    .merged_c (merged_c)
  );

  // Acceptance-time error check; 33-bit sum so addresses near the top cannot wrap.
  always_comb begin
    span_c = 2'd0;
    case (req_size)
      SZ_HALF: span_c = 2'd1;
      SZ_WORD: span_c = 2'd3;
      default: span_c = 2'd0;
    endcase
    last_byte_c = {1'b0, req_addr} + 33'(span_c);
    acc_err_c   = (req_size == SZ_RSVD) || is_misaligned(req_size, req_addr[1:0]) ||
                  (last_byte_c >= 33'(MEM_BYTES));
  end

  assign two_beat_c  = (req.size == SZ_WORD) || (req.write && (req.size == SZ_BYTE));
  assign base_addr_c = {req.addr[31:1], 1'b0};

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state and memory strobes; reset suppresses strobes on the edge it takes effect.
  always_comb begin
    state_nxt    = state;
    req_ready    = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_write_en = 1'b0;
    mem_read     = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = acc_err_c ? ST_RESP : ST_ACC0;
      end
      ST_ACC0: begin
        mem_addr = base_addr_c;
        if (!req.write || (req.size == SZ_BYTE)) begin
          mem_read = 1'b1;
        end else begin
          mem_write_en = 1'b1;
          mem_wdata    = (req.size == SZ_WORD) ? req.wdata[31:16] : req.wdata[15:0];
        end
        state_nxt = two_beat_c ? ST_ACC1 : ST_RESP;
      end
      ST_ACC1: begin
        if (req.size == SZ_WORD) begin
          mem_addr = base_addr_c + 32'd2;
          if (req.write) begin
            mem_write_en = 1'b1;
            mem_wdata    = req.wdata[15:0];
          end else begin
            mem_read = 1'b1;
          end
        end else begin
          mem_addr     = base_addr_c;
          mem_write_en = 1'b1;
          mem_wdata    = merged_c;
        end
        state_nxt = ST_RESP;
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (rst) begin
      mem_write_en = 1'b0;
      mem_read     = 1'b0;
    end
  end

  // Request capture, read-data holding and registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      req        <= '0;
      err_q      <= 1'b0;
      hold       <= '0;
      lo         <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            req.write <= req_write;
            req.size  <= req_size;
            req.sgn   <= req_signed;
            req.addr  <= req_addr;
            req.wdata <= req_wdata;
            err_q     <= acc_err_c;
          end
        end
        ST_ACC0: if (mem_read) hold <= mem_rdata;
        ST_ACC1: if (mem_read) lo <= mem_rdata;
        ST_RESP: begin
          resp_valid <= 1'b1;
          resp_err   <= err_q;
          resp_rdata <= (err_q || req.write) ? 32'd0 : ld_data_c;
        end
        default: ;
      endcase
    end
  end

endmodule
